// File: rtl/boot_controller.sv
// boot_controller: streams a program image into the SAP-1 RAM, then releases and supervises the CPU.
// Define BOOT_CHECKSUM_EN to require a trailing checksum byte after the image.
module boot_controller #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int TIMEOUT      = 50000,
  parameter int RESET_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   load_len,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  cpu_reset,
  input  logic                  cpu_halted,
  output logic                  busy,
  output logic                  done,
  output logic                  timed_out,
  output logic [31:0]           cycle_count
`ifdef BOOT_CHECKSUM_EN
  ,
  output logic                  checksum_err
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RESET, S_RUN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH:0] FULL_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [31:0]         RUN_LAST = 32'(TIMEOUT - 1);
  localparam logic [31:0]         RST_LAST = 32'(RESET_CYCLES - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic [31:0]           rst_cnt_q, rst_cnt_d;
  logic [31:0]           cycle_count_q, cycle_count_d;
  logic                  timed_out_q, timed_out_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  fail_hold;
`ifdef BOOT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  checksum_err_q, checksum_err_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      remaining_q    <= '0;
      addr_q         <= '0;
      ram_we_q       <= 1'b0;
      ram_addr_q     <= '0;
      ram_wdata_q    <= '0;
      rst_cnt_q      <= '0;
      cycle_count_q  <= '0;
      timed_out_q    <= 1'b0;
      cpu_reset_q    <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
      sum_q          <= '0;
      checksum_err_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      addr_q         <= addr_d;
      ram_we_q       <= ram_we_d;
      ram_addr_q     <= ram_addr_d;
      ram_wdata_q    <= ram_wdata_d;
      rst_cnt_q      <= rst_cnt_d;
      cycle_count_q  <= cycle_count_d;
      timed_out_q    <= timed_out_d;
      cpu_reset_q    <= cpu_reset_d;
`ifdef BOOT_CHECKSUM_EN
      sum_q          <= sum_d;
      checksum_err_q <= checksum_err_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    remaining_d    = remaining_q;
    addr_d         = addr_q;
    ram_we_d       = 1'b0;
    ram_addr_d     = ram_addr_q;
    ram_wdata_d    = ram_wdata_q;
    rst_cnt_d      = rst_cnt_q;
    cycle_count_d  = cycle_count_q;
    timed_out_d    = timed_out_q;
`ifdef BOOT_CHECKSUM_EN
    sum_d          = sum_q;
    checksum_err_d = checksum_err_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d       = S_LOAD;
          remaining_d   = (load_len == '0) ? FULL_LEN : load_len;
          addr_d        = '0;
          cycle_count_d = '0;
          timed_out_d   = 1'b0;
`ifdef BOOT_CHECKSUM_EN
          sum_d          = '0;
          checksum_err_d = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (in_valid) begin
`ifdef BOOT_CHECKSUM_EN
          // remaining == 0 means the image is in and this byte is the trailer
          if (remaining_q == '0) begin
            if ((sum_q + in_data) == '0) begin
              state_d   = S_RESET;
              rst_cnt_d = '0;
            end else begin
              state_d        = S_DONE;
              checksum_err_d = 1'b1;
            end
          end else begin
            ram_we_d    = 1'b1;
            ram_addr_d  = addr_q;
            ram_wdata_d = in_data;
            addr_d      = addr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
            sum_d       = sum_q + in_data;
          end
`else
          ram_we_d    = 1'b1;
          ram_addr_d  = addr_q;
          ram_wdata_d = in_data;
          addr_d      = addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == LEN_ONE) begin
            state_d   = S_RESET;
            rst_cnt_d = '0;
          end
`endif
        end
      end
      S_RESET: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + 32'd1;
        end
      end
      S_RUN: begin
        // halt has priority over a timeout landing on the same cycle
        if (cpu_halted) begin
          state_d     = S_DONE;
          timed_out_d = 1'b0;
        end else if (cycle_count_q == RUN_LAST) begin
          state_d     = S_DONE;
          timed_out_d = 1'b1;
        end else if (cycle_count_q != '1) begin
          cycle_count_d = cycle_count_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef BOOT_CHECKSUM_EN
    fail_hold = timed_out_d | checksum_err_d;
`else
    fail_hold = timed_out_d;
`endif
    // After a clean halt the CPU stays out of reset so its OUT register remains visible
    case (state_d)
      S_RUN:   cpu_reset_d = 1'b0;
      S_DONE:  cpu_reset_d = fail_hold;
      default: cpu_reset_d = 1'b1;
    endcase
  end

  assign in_ready    = (state_q == S_LOAD);
  assign busy        = (state_q == S_LOAD) || (state_q == S_RESET) || (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign cpu_reset   = cpu_reset_q;
  assign timed_out   = timed_out_q;
  assign cycle_count = cycle_count_q;
`ifdef BOOT_CHECKSUM_EN
  assign checksum_err = checksum_err_q;
`endif

endmodule
